srec_word_packer: RTL and testbench

//  Packs the byte-write stream from srec_parser (address, byte, enable) into aligned

---
 rtl/srec_loader_pkg.sv | 28 ++
 rtl/srec_lane_merge.sv | 28 ++
 rtl/srec_word_packer.sv | 166 ++++++++++++++++
 tb/tb_srec_word_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/srec_loader_pkg.sv
// Shared constants and address helpers for the SREC loader path
// (srec_parser users and srec_word_packer).
package srec_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_ADDR_W = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Byte lane inside a word; callers truncate to their lane width.
    function automatic logic [MAX_ADDR_W-1:0] lane_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int lane_w);
        return addr & ((64'd1 << lane_w) - 64'd1);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int lane_w);
        return addr >> lane_w;
    endfunction

endpackage

// File: rtl/srec_lane_merge.sv
// Combinational byte-lane merge: drops one byte into its lane of a word and
// sets the matching enable bit; a repeated lane is simply overwritten.
module srec_lane_merge
    import srec_loader_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int LANE_IW    = 2
) (
    input  logic [BYTE_W*WORD_BYTES-1:0] word,
    input  logic [WORD_BYTES-1:0]        enable,
    input  logic [LANE_IW-1:0]           lane,
    input  logic [BYTE_W-1:0]            data_byte,
    output logic [BYTE_W*WORD_BYTES-1:0] merged_word,
    output logic [WORD_BYTES-1:0]        merged_enable
);

    always_comb begin
        merged_word   = word;
        merged_enable = enable;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (lane == LANE_IW'(k)) begin
                merged_word[k*BYTE_W +: BYTE_W] = data_byte;
                merged_enable[k]                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srec_word_packer.sv
// Packs parser byte writes into aligned words with byte enables and a valid/ready
// output. Optional counters enabled by defining SREC_PACKER_STATS_EN.
module srec_word_packer
    import srec_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [ADDR_WIDTH-1:0]                    byte_address,
    input  logic [7:0]                               byte_data,
    input  logic                                     byte_valid,
    input  logic                                     flush,
    output logic [ADDR_WIDTH-clog2(WORD_BYTES)-1:0]  word_address,
    output logic [8*WORD_BYTES-1:0]                  word_data,
    output logic [WORD_BYTES-1:0]                    word_byte_enable,
    output logic                                     word_valid,
    input  logic                                     word_ready,
    output logic                                     overflow,
    output logic [15:0]                              stat_words,
    output logic [15:0]                              stat_partial
);

    localparam int LANE_W  = clog2(WORD_BYTES);
    localparam int LANE_IW = (LANE_W == 0) ? 1 : LANE_W;
    localparam int WADDR_W = ADDR_WIDTH - LANE_W;
    localparam int DATA_W  = BYTE_W * WORD_BYTES;
    localparam logic [WORD_BYTES-1:0] ALL_LANES = '1;

    logic [MAX_ADDR_W-1:0] addr_ext;
    logic [WADDR_W-1:0]    in_word;
    logic [LANE_IW-1:0]    in_lane;

    logic [WADDR_W-1:0]    acc_addr, acc_addr_nx;
    logic [DATA_W-1:0]     acc_data, acc_data_nx;
    logic [WORD_BYTES-1:0] acc_be, acc_be_nx;
    logic                  pending_flush, pending_flush_nx;

    logic                  eff_flush;
    logic                  acc_hit;
    logic [DATA_W-1:0]     base_data, merged_data;
    logic [WORD_BYTES-1:0] base_be, merged_be;

    logic                  evict;
    logic [WADDR_W-1:0]    ev_addr;
    logic [DATA_W-1:0]     ev_data;
    logic [WORD_BYTES-1:0] ev_be;
    logic                  can_load;

    assign addr_ext = MAX_ADDR_W'(byte_address);
    assign in_word  = WADDR_W'(word_index(addr_ext, LANE_W));
    assign in_lane  = LANE_IW'(lane_index(addr_ext, LANE_W));

    // A pending flush behaves exactly like a fresh flush request on the next cycle.
    assign eff_flush = flush | pending_flush;
    assign acc_hit   = (acc_be != '0) && (acc_addr == in_word);
    assign base_data = acc_hit ? acc_data : '0;
    assign base_be   = acc_hit ? acc_be : '0;

    srec_lane_merge #(
        .WORD_BYTES (WORD_BYTES),
        .LANE_IW    (LANE_IW)
    ) u_lane_merge (
        .word          (base_data),
        .enable        (base_be),
        .lane          (in_lane),
        .data_byte     (byte_data),
        .merged_word   (merged_data),
        .merged_enable (merged_be)
    );

    always_comb begin
        acc_addr_nx      = acc_addr;
        acc_data_nx      = acc_data;
        acc_be_nx        = acc_be;
        pending_flush_nx = 1'b0;
        evict            = 1'b0;
        ev_addr          = acc_addr;
        ev_data          = acc_data;
        ev_be            = acc_be;
        if (byte_valid) begin
            if ((acc_be == '0) || acc_hit) begin
                if ((merged_be == ALL_LANES) || eff_flush) begin
                    evict       = 1'b1;
                    ev_addr     = in_word;
                    ev_data     = merged_data;
                    ev_be       = merged_be;
                    acc_data_nx = '0;
                    acc_be_nx   = '0;
                end else begin
                    acc_addr_nx = in_word;
                    acc_data_nx = merged_data;
                    acc_be_nx   = merged_be;
                end
            end else begin
                // Address change: old word leaves now, new byte starts over.
                evict            = 1'b1;
                acc_addr_nx      = in_word;
                acc_data_nx      = merged_data;
                acc_be_nx        = merged_be;
                pending_flush_nx = eff_flush;
            end
        end else if (eff_flush && (acc_be != '0)) begin
            evict       = 1'b1;
            acc_data_nx = '0;
            acc_be_nx   = '0;
        end
    end

    assign can_load = !word_valid || word_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_addr         <= '0;
            acc_data         <= '0;
            acc_be           <= '0;
            pending_flush    <= 1'b0;
            word_address     <= '0;
            word_data        <= '0;
            word_byte_enable <= '0;
            word_valid       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            acc_addr      <= acc_addr_nx;
            acc_data      <= acc_data_nx;
            acc_be        <= acc_be_nx;
            pending_flush <= pending_flush_nx;
            if (evict) begin
                if (can_load) begin
                    word_address     <= ev_addr;
                    word_data        <= ev_data;
                    word_byte_enable <= ev_be;
                    word_valid       <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef SREC_PACKER_STATS_EN
    logic accept;
    assign accept = word_valid & word_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_words   <= '0;
            stat_partial <= '0;
        end else if (accept) begin
            if (stat_words != 16'hFFFF) begin
                stat_words <= stat_words + 16'd1;
            end
            if ((word_byte_enable != ALL_LANES) && (stat_partial != 16'hFFFF)) begin
                stat_partial <= stat_partial + 16'd1;
            end
        end
    end
`else
    assign stat_words   = 16'h0;
    assign stat_partial = 16'h0;
`endif

endmodule

// File: tb/tb_srec_word_packer.sv
// Directed self-checking bench for srec_word_packer (WORD_BYTES=4, ADDR_WIDTH=32).
module tb_srec_word_packer;

    logic        clock;
    logic        reset;
    logic [31:0] byte_address;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        flush;
    logic [29:0] word_address;
    logic [31:0] word_data;
    logic [3:0]  word_byte_enable;
    logic        word_valid;
    logic        word_ready;
    logic        overflow;
    logic [15:0] stat_words;
    logic [15:0] stat_partial;

    int vectors;
    int miscompares;

    srec_word_packer #(
        .ADDR_WIDTH (32),
        .WORD_BYTES (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .byte_address     (byte_address),
        .byte_data        (byte_data),
        .byte_valid       (byte_valid),
        .flush            (flush),
        .word_address     (word_address),
        .word_data        (word_data),
        .word_byte_enable (word_byte_enable),
        .word_valid       (word_valid),
        .word_ready       (word_ready),
        .overflow         (overflow),
        .stat_words       (stat_words),
        .stat_partial     (stat_partial)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus from a negedge; returns at the next negedge.
    task automatic step(input logic bv, input logic [31:0] a, input logic [7:0] d, input logic fl);
        byte_valid   = bv;
        byte_address = a;
        byte_data    = d;
        flush        = fl;
        @(negedge clock);
        byte_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [29:0] ea, input logic [31:0] ed,
                               input logic [3:0] eb);
        vectors++;
        if (word_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s valid: got %b expected 1", name, word_valid);
        end
        vectors++;
        if (word_address !== ea) begin
            miscompares++;
            $display("[TB] FAIL %s addr: got %h expected %h", name, word_address, ea);
        end
        vectors++;
        if (word_data !== ed) begin
            miscompares++;
            $display("[TB] FAIL %s data: got %h expected %h", name, word_data, ed);
        end
        vectors++;
        if (word_byte_enable !== eb) begin
            miscompares++;
            $display("[TB] FAIL %s be: got %b expected %b", name, word_byte_enable, eb);
        end
    endtask

    task automatic expect_idle(input string name);
        vectors++;
        if (word_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s valid: got %b expected 0", name, word_valid);
        end
    endtask

    task automatic expect_cleared(input string name);
        vectors++;
        if ({word_valid, overflow, word_address, word_data, word_byte_enable,
             stat_words, stat_partial} !== '0) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b ovf=%b a=%h d=%h be=%b sw=%0d sp=%0d expected all 0",
                     name, word_valid, overflow, word_address, word_data, word_byte_enable,
                     stat_words, stat_partial);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        byte_valid   = 1'b0;
        flush        = 1'b0;
        byte_address = '0;
        byte_data    = '0;
        word_ready   = 1'b1;
        repeat (3) @(negedge clock);
        expect_cleared("reset_state");
        reset = 1'b0;
        @(negedge clock);
        expect_idle("after_reset");
    endtask

    task automatic test_full_word();
        step(1'b1, 32'h100, 8'h11, 1'b0);
        step(1'b1, 32'h101, 8'h22, 1'b0);
        step(1'b1, 32'h102, 8'h33, 1'b0);
        expect_idle("full_word_early");
        step(1'b1, 32'h103, 8'h44, 1'b0);
        expect_word("full_word", 30'h40, 32'h44332211, 4'b1111);
    endtask

    task automatic test_address_change();
        step(1'b1, 32'h105, 8'h22, 1'b0);
        step(1'b1, 32'h106, 8'h33, 1'b0);
        step(1'b1, 32'h200, 8'h55, 1'b0);
        expect_word("addr_change", 30'h41, 32'h00332200, 4'b0110);
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("addr_change_accepted");
        vectors++;
`ifdef SREC_PACKER_STATS_EN
        if (stat_words !== 16'd2 || stat_partial !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL stats: got %0d/%0d expected 2/1", stat_words, stat_partial);
        end
`else
        if (stat_words !== 16'd0 || stat_partial !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL stats_tied: got %0d/%0d expected 0/0", stat_words, stat_partial);
        end
`endif
        step(1'b0, 32'h0, 8'h00, 1'b1);
        expect_word("held_flush", 30'h80, 32'h00000055, 4'b0001);
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("held_flush_accepted");
    endtask

    task automatic test_flush_with_byte();
        step(1'b1, 32'h203, 8'h77, 1'b0);
        expect_idle("flush_byte_pre");
        step(1'b1, 32'h300, 8'h99, 1'b1);
        expect_word("flush_old", 30'h80, 32'h77000000, 4'b1000);
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_word("flush_pending", 30'hC0, 32'h00000099, 4'b0001);
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("flush_pending_done");
    endtask

    task automatic test_back_to_back_stall();
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 8'hA0 + 8'(i), 1'b0);
        expect_word("stall_first", 30'h0, 32'hA3A2A1A0, 4'b1111);
        for (int i = 4; i < 8; i++) step(1'b1, 32'(i), 8'hB0 + 8'(i), 1'b0);
        expect_word("stall_hold", 30'h0, 32'hA3A2A1A0, 4'b1111);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow: got %b expected 1", overflow);
        end
        word_ready = 1'b1;
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("stall_drained");
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("stall_no_second");
    endtask

    task automatic test_overwrite_lane();
        step(1'b1, 32'h10, 8'hAA, 1'b0);
        step(1'b1, 32'h10, 8'hBB, 1'b0);
        expect_idle("overwrite_pre");
        step(1'b0, 32'h0, 8'h00, 1'b1);
        expect_word("overwrite", 30'h4, 32'h000000BB, 4'b0001);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
        end
        step(1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_midword();
        step(1'b1, 32'h20, 8'hC0, 1'b0);
        step(1'b1, 32'h21, 8'hC1, 1'b0);
        reset = 1'b1;
        #1;
        expect_cleared("midword_reset");
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 32'h0, 8'h00, 1'b1);
        expect_idle("flush_after_reset");
        step(1'b0, 32'h0, 8'h00, 1'b0);
        expect_idle("flush_after_reset_late");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_full_word();
        test_address_change();
        test_flush_with_byte();
        test_back_to_back_stall();
        test_overwrite_lane();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
